// File: rtl/tpm_host_driver.sv
// tpm_host_driver
//   Hardware initiator for the TPM accelerator's slave-register command protocol.
//   Takes one high-level request at a time (RNG, SHA-1 init block, SHA-1 next block),
//   issues the opcode sequence (load1, load2, init/next, or a single RNG command)
//   through the command registers, waits for the result registers, and returns the
//   digest or random word on a valid/ready response port.
//
// Ports
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_req_valid / o_req_ready    request handshake; i_req_op selects the operation
//                                (0 RNG, 1 SHA init, 2 SHA next, 3 illegal)
//   i_req_block                  SHA block, ignored for RNG
//   o_resp_valid / i_resp_ready  response handshake
//   o_resp_data, o_resp_error    digest or zero-extended RNG word; timeout/illegal flag
//   o_cmd_status, o_cmd_arg0..7  command registers towards the target
//   i_rsp_status, i_rsp_arg0..4  response registers from the target
//   i_status_clear               target's command-consumed pulse
module tpm_host_driver #(
    parameter int unsigned C_REG_SIZE        = 32,
    parameter int unsigned C_SHA_CHUNK_SIZE  = 512,
    parameter int unsigned C_SHA_DIGEST_SIZE = 160,
    parameter int unsigned C_RNG_SIZE        = 32,
    parameter int unsigned C_TIMEOUT         = 65535
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic [1:0]                   i_req_op,
    input  logic [C_SHA_CHUNK_SIZE-1:0]  i_req_block,
    output logic                         o_resp_valid,
    input  logic                         i_resp_ready,
    output logic [C_SHA_DIGEST_SIZE-1:0] o_resp_data,
    output logic                         o_resp_error,
    output logic [C_REG_SIZE-1:0]        o_cmd_status,
    output logic [C_REG_SIZE-1:0]        o_cmd_arg0,
    output logic [C_REG_SIZE-1:0]        o_cmd_arg1,
    output logic [C_REG_SIZE-1:0]        o_cmd_arg2,
    output logic [C_REG_SIZE-1:0]        o_cmd_arg3,
    output logic [C_REG_SIZE-1:0]        o_cmd_arg4,
    output logic [C_REG_SIZE-1:0]        o_cmd_arg5,
    output logic [C_REG_SIZE-1:0]        o_cmd_arg6,
    output logic [C_REG_SIZE-1:0]        o_cmd_arg7,
    input  logic [C_REG_SIZE-1:0]        i_rsp_status,
    input  logic [C_REG_SIZE-1:0]        i_rsp_arg0,
    input  logic [C_REG_SIZE-1:0]        i_rsp_arg1,
    input  logic [C_REG_SIZE-1:0]        i_rsp_arg2,
    input  logic [C_REG_SIZE-1:0]        i_rsp_arg3,
    input  logic [C_REG_SIZE-1:0]        i_rsp_arg4,
    input  logic                         i_status_clear
);

    localparam int unsigned       C_TMR_W    = $clog2(C_TIMEOUT + 1);
    localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(C_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad1,
        StLoad2,
        StStart,
        StWait,
        StResp
    } state_e;

    state_e                       r_state;
    logic [1:0]                   r_op;
    logic [C_SHA_CHUNK_SIZE-1:0]  r_block;
    logic [4:0]                   r_opcode;
    logic [C_REG_SIZE-1:0]        r_args [8];
    logic [C_SHA_DIGEST_SIZE-1:0] r_resp_data;
    logic                         r_resp_error;
    logic [C_TMR_W-1:0]           r_timer;
    logic                         r_clr_q;

    state_e                       w_state_d;
    logic [1:0]                   w_op_d;
    logic [C_SHA_CHUNK_SIZE-1:0]  w_block_d;
    logic [4:0]                   w_opcode_d;
    logic [C_REG_SIZE-1:0]        w_args_d [8];
    logic [C_SHA_DIGEST_SIZE-1:0] w_resp_data_d;
    logic                         w_resp_error_d;
    logic [C_TMR_W-1:0]           w_timer_d;

    logic                         w_ack;
    logic                         w_expired;
    logic                         w_issue;
    logic                         w_counting;
    logic                         w_result_ready;
    logic [C_SHA_DIGEST_SIZE-1:0] w_rng_data;
    logic [C_SHA_DIGEST_SIZE-1:0] w_sha_data;
    logic                         w_unused;

    // Only a rising edge of status_clear acknowledges, so a level left high by the
    // previous command cannot retire the next one.
    assign w_ack          = i_status_clear && !r_clr_q;
    assign w_expired      = (r_timer == C_TMR_LAST);
    assign w_issue        = (r_state == StLoad1) || (r_state == StLoad2) || (r_state == StStart);
    assign w_counting     = w_issue || (r_state == StWait);
    assign w_result_ready = (i_rsp_status[1:0] == 2'b11);
    assign w_sha_data     = C_SHA_DIGEST_SIZE'({i_rsp_arg4, i_rsp_arg3, i_rsp_arg2,
                                                i_rsp_arg1, i_rsp_arg0});
    assign w_unused       = ^i_rsp_status[C_REG_SIZE-1:2];

    always_comb begin
        w_rng_data                   = '0;
        w_rng_data[C_RNG_SIZE-1:0]   = i_rsp_arg0[C_RNG_SIZE-1:0];
    end

    always_comb begin
        w_state_d      = r_state;
        w_op_d         = r_op;
        w_block_d      = r_block;
        w_resp_data_d  = r_resp_data;
        w_resp_error_d = r_resp_error;

        case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    w_op_d    = i_req_op;
                    w_block_d = i_req_block;
                    case (i_req_op)
                        2'd0:       w_state_d = StStart;
                        2'd1, 2'd2: w_state_d = StLoad1;
                        default: begin
                            w_state_d      = StResp;
                            w_resp_error_d = 1'b1;
                            w_resp_data_d  = '0;
                        end
                    endcase
                end
            end
            StLoad1, StLoad2, StStart: begin
                // Ack wins over a simultaneous expiry.
                if (w_ack) begin
                    if (r_state == StLoad1) begin
                        w_state_d = StLoad2;
                    end else if (r_state == StLoad2) begin
                        w_state_d = StStart;
                    end else begin
                        w_state_d = StWait;
                    end
                end else if (w_expired) begin
                    w_state_d      = StResp;
                    w_resp_error_d = 1'b1;
                    w_resp_data_d  = '0;
                end
            end
            StWait: begin
                if (w_result_ready) begin
                    w_state_d      = StResp;
                    w_resp_error_d = 1'b0;
                    w_resp_data_d  = (r_op == 2'd0) ? w_rng_data : w_sha_data;
                end else if (w_expired) begin
                    w_state_d      = StResp;
                    w_resp_error_d = 1'b1;
                    w_resp_data_d  = '0;
                end
            end
            StResp: begin
                if (i_resp_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Command registers are a function of the state being entered, so they are
        // loaded on entry and stay constant for the whole issue state.
        w_opcode_d = '0;
        for (int i = 0; i < 8; i++) begin
            w_args_d[i] = '0;
        end
        case (w_state_d)
            StLoad1: begin
                w_opcode_d = 5'd1;
                for (int i = 0; i < 8; i++) begin
                    w_args_d[i] = w_block_d[C_REG_SIZE*i +: C_REG_SIZE];
                end
            end
            StLoad2: begin
                w_opcode_d = 5'd2;
                for (int i = 0; i < 8; i++) begin
                    w_args_d[i] = w_block_d[C_REG_SIZE*(8+i) +: C_REG_SIZE];
                end
            end
            StStart: begin
                case (w_op_d)
                    2'd1:    w_opcode_d = 5'd3;
                    2'd2:    w_opcode_d = 5'd4;
                    default: w_opcode_d = 5'd0;
                endcase
            end
            default: ;
        endcase

        // Timer restarts on every state change.
        if (w_state_d != r_state) begin
            w_timer_d = '0;
        end else if (w_counting) begin
            w_timer_d = r_timer + 1'b1;
        end else begin
            w_timer_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_op         <= '0;
            r_block      <= '0;
            r_opcode     <= '0;
            for (int i = 0; i < 8; i++) begin
                r_args[i] <= '0;
            end
            r_resp_data  <= '0;
            r_resp_error <= 1'b0;
            r_timer      <= '0;
            r_clr_q      <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_op         <= w_op_d;
            r_block      <= w_block_d;
            r_opcode     <= w_opcode_d;
            r_args       <= w_args_d;
            r_resp_data  <= w_resp_data_d;
            r_resp_error <= w_resp_error_d;
            r_timer      <= w_timer_d;
            r_clr_q      <= i_status_clear;
        end
    end

    assign o_req_ready  = (r_state == StIdle);
    assign o_resp_valid = (r_state == StResp);
    assign o_resp_data  = r_resp_data;
    assign o_resp_error = r_resp_error;
    // Valid is gated combinationally so the target never sees it on the edge after
    // it consumed a command.
    assign o_cmd_status = {{(C_REG_SIZE-6){1'b0}}, r_opcode, w_issue && !i_status_clear};
    assign o_cmd_arg0   = r_args[0];
    assign o_cmd_arg1   = r_args[1];
    assign o_cmd_arg2   = r_args[2];
    assign o_cmd_arg3   = r_args[3];
    assign o_cmd_arg4   = r_args[4];
    assign o_cmd_arg5   = r_args[5];
    assign o_cmd_arg6   = r_args[6];
    assign o_cmd_arg7   = r_args[7];

endmodule

// File: tb/tb_tpm_host_driver.sv
// Bench for tpm_host_driver: a behavioural TPM target answers the command registers,
// expected commands and responses are queued at stimulus time and retired by the
// target model and the response monitor.
module tb_tpm_host_driver;

    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'd0;
    logic [511:0] req_block = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [159:0] resp_data;
    logic         resp_error;
    logic [31:0]  cmd_status;
    logic [31:0]  cmd_arg [8];
    logic [31:0]  rsp_status = 32'h1;
    logic [31:0]  rsp_arg [5];
    logic         status_clear = 1'b0;

    tpm_host_driver #(
        .C_REG_SIZE       (32),
        .C_SHA_CHUNK_SIZE (512),
        .C_SHA_DIGEST_SIZE(160),
        .C_RNG_SIZE       (32),
        .C_TIMEOUT        (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_op      (req_op),
        .i_req_block   (req_block),
        .o_resp_valid  (resp_valid),
        .i_resp_ready  (resp_ready),
        .o_resp_data   (resp_data),
        .o_resp_error  (resp_error),
        .o_cmd_status  (cmd_status),
        .o_cmd_arg0    (cmd_arg[0]),
        .o_cmd_arg1    (cmd_arg[1]),
        .o_cmd_arg2    (cmd_arg[2]),
        .o_cmd_arg3    (cmd_arg[3]),
        .o_cmd_arg4    (cmd_arg[4]),
        .o_cmd_arg5    (cmd_arg[5]),
        .o_cmd_arg6    (cmd_arg[6]),
        .o_cmd_arg7    (cmd_arg[7]),
        .i_rsp_status  (rsp_status),
        .i_rsp_arg0    (rsp_arg[0]),
        .i_rsp_arg1    (rsp_arg[1]),
        .i_rsp_arg2    (rsp_arg[2]),
        .i_rsp_arg3    (rsp_arg[3]),
        .i_rsp_arg4    (rsp_arg[4]),
        .i_status_clear(status_clear)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string got, input string req);
        checks++;
        errors++;
        $display("FAIL %s: got %s required %s", name, got, req);
    endtask

    typedef struct {
        logic         err;
        logic [159:0] data;
        bit           is_to;
    } resp_t;

    typedef struct {
        logic [4:0]   opc;
        logic [255:0] args;
        bit           chk_args;
    } cmd_t;

    resp_t exp_q[$];
    cmd_t  exp_cmd_q[$];

    // Target behaviour knobs, set by the stimulus before each request.
    int          t_ack = 0;
    int          t_hold = 1;
    int          t_hold_start = 1;
    int          t_res = 1;
    bit          t_never = 1'b0;
    logic [31:0] t_words [5];
    int          bp_left = 0;
    int          resp_done = 0;
    int          wait_entry = 0;
    int          gate_seen = 0;

    // Target model: consumes a command after t_ack cycles of visible valid, holds
    // status_clear, and posts the result t_res cycles after an execute command.
    initial begin : target
        int   hold_cnt;
        int   ack_cnt;
        int   res_cnt;
        cmd_t e;
        logic [255:0] args;
        logic [4:0]   opc;
        hold_cnt = 0;
        ack_cnt  = 0;
        res_cnt  = 0;
        for (int i = 0; i < 5; i++) rsp_arg[i] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_cnt     = 0;
                ack_cnt      = 0;
                res_cnt      = 0;
                status_clear = 1'b0;
                rsp_status   = 32'h1;
                for (int i = 0; i < 5; i++) rsp_arg[i] = '0;
            end else begin
                if (status_clear) begin
                    chk("valid_gated", 256'(cmd_status[0]), 256'(0));
                    if (cmd_status[5:1] == 5'd1) gate_seen++;
                end
                if (res_cnt > 0) begin
                    res_cnt--;
                    if (res_cnt == 0) begin
                        for (int i = 0; i < 5; i++) rsp_arg[i] = t_words[i];
                        rsp_status = 32'h3;
                    end
                end
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    if (hold_cnt == 0) status_clear = 1'b0;
                end else if (cmd_status[0]) begin
                    if (ack_cnt < t_ack) begin
                        ack_cnt++;
                    end else begin
                        ack_cnt = 0;
                        opc = cmd_status[5:1];
                        for (int i = 0; i < 8; i++) args[32*i +: 32] = cmd_arg[i];
                        if (exp_cmd_q.size() == 0) begin
                            fail("unexpected_cmd", $sformatf("opcode %0d", opc), "no command");
                        end else begin
                            e = exp_cmd_q.pop_front();
                            chk("cmd_opcode", 256'(opc), 256'(e.opc));
                            if (e.chk_args) chk("cmd_args", args, e.args);
                        end
                        status_clear = 1'b1;
                        rsp_status   = 32'h1;
                        if (opc == 5'd0 || opc == 5'd3 || opc == 5'd4) begin
                            hold_cnt   = t_hold_start;
                            wait_entry = cyc + 1;
                            if (!t_never) res_cnt = t_res;
                        end else begin
                            hold_cnt = t_hold;
                        end
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on each handshake, applies backpressure.
    initial begin : monitor
        bit    holding;
        resp_t r;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                holding    = 1'b0;
                resp_ready = 1'b1;
            end else if (resp_valid) begin
                if (!holding) begin
                    holding = 1'b1;
                    if (exp_q.size() > 0 && exp_q[0].is_to)
                        chk("timeout_latency", 256'(cyc - wait_entry), 256'(TMO));
                end
                if (bp_left > 0) begin
                    resp_ready = 1'b0;
                    bp_left--;
                    chk("bp_req_ready", 256'(req_ready), 256'(0));
                    chk("bp_cmd_status", 256'(cmd_status), 256'(0));
                    if (exp_q.size() > 0) begin
                        chk("bp_hold_error", 256'(resp_error), 256'(exp_q[0].err));
                        chk("bp_hold_data", 256'(resp_data), 256'(exp_q[0].data));
                    end
                end else begin
                    resp_ready = 1'b1;
                    if (exp_q.size() == 0) begin
                        fail("unexpected_resp", "response", "none");
                    end else begin
                        r = exp_q.pop_front();
                        chk("resp_error", 256'(resp_error), 256'(r.err));
                        chk("resp_data", 256'(resp_data), 256'(r.data));
                    end
                    holding = 1'b0;
                    resp_done++;
                end
            end
        end
    end

    // Protocol rule: loads carry the block split into 32-bit words, then an execute
    // opcode chosen by the request type.
    task automatic push_cmds(input logic [1:0] op, input logic [511:0] blk);
        cmd_t c;
        if (op == 2'd1 || op == 2'd2) begin
            c = '{opc: 5'd1, args: blk[255:0], chk_args: 1'b1};
            exp_cmd_q.push_back(c);
            c = '{opc: 5'd2, args: blk[511:256], chk_args: 1'b1};
            exp_cmd_q.push_back(c);
        end
        if (op != 2'd3) begin
            c = '{opc: (op == 2'd0) ? 5'd0 : (op == 2'd1) ? 5'd3 : 5'd4, args: '0, chk_args: 1'b0};
            exp_cmd_q.push_back(c);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [511:0] blk);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) fail("req_accept", "req_ready low", "req_ready high");
        req_valid = 1'b1;
        req_op    = op;
        req_block = blk;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [511:0] blk, input int bp,
                          input bit never);
        resp_t r;
        int    tgt;
        int    n;
        bp_left = bp;
        t_never = never;
        push_cmds(op, blk);
        if (op == 2'd3 || never) begin
            r = '{err: 1'b1, data: '0, is_to: (op != 2'd3)};
        end else if (op == 2'd0) begin
            r = '{err: 1'b0, data: {128'b0, t_words[0]}, is_to: 1'b0};
        end else begin
            r = '{err: 1'b0, data: {t_words[4], t_words[3], t_words[2], t_words[1], t_words[0]},
                  is_to: 1'b0};
        end
        exp_q.push_back(r);
        tgt = resp_done + 1;
        issue(op, blk);
        n = 0;
        while (resp_done < tgt && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (resp_done < tgt) begin
            fail("resp_wait", "no response", "response");
            exp_q.delete();
            exp_cmd_q.delete();
        end
        chk("cmds_drained", 256'(exp_cmd_q.size()), 256'(0));
        @(negedge clk);
        chk("req_ready_after", 256'(req_ready), 256'(1));
    endtask

    task automatic rand_words();
        for (int i = 0; i < 5; i++) t_words[i] = $urandom;
    endtask

    initial begin : stim
        logic [511:0] blk;
        logic [1:0]   op;
        int           n;

        for (int i = 0; i < 5; i++) t_words[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 256'(req_ready), 256'(1));
        chk("rst_resp_valid", 256'(resp_valid), 256'(0));
        chk("rst_cmd_status", 256'(cmd_status), 256'(0));
        chk("rst_resp_data", 256'(resp_data), 256'(0));
        chk("rst_resp_error", 256'(resp_error), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // SHA init with counting block words.
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = 32'(i);
        t_words[0] = 32'h11; t_words[1] = 32'h22; t_words[2] = 32'h33;
        t_words[3] = 32'h44; t_words[4] = 32'h55;
        t_ack = 1; t_hold = 1; t_hold_start = 1; t_res = 3;
        do_req(2'd1, blk, 0, 1'b0);

        // RNG.
        t_words[0] = 32'hDEADBEEF;
        t_ack = 2; t_res = 10;
        do_req(2'd0, blk, 0, 1'b0);

        // Stale status_clear: previous execute leaves it high into the next LOAD1.
        t_ack = 0; t_res = 1; t_hold_start = 10;
        rand_words();
        do_req(2'd1, blk, 0, 1'b0);
        gate_seen = 0;
        t_hold_start = 1;
        rand_words();
        blk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_req(2'd2, blk, 0, 1'b0);
        chk("stale_gate_seen", 256'(gate_seen > 0), 256'(1));

        // Timeout in WAIT.
        t_ack = 1; t_hold = 1;
        do_req(2'd0, blk, 0, 1'b1);

        // Illegal op under backpressure.
        do_req(2'd3, blk, 5, 1'b0);

        // Randomised traffic.
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
            rand_words();
            t_ack        = $urandom_range(0, 4);
            t_hold       = $urandom_range(1, 3);
            t_hold_start = $urandom_range(1, 3);
            t_res        = $urandom_range(1, 8);
            op = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(op, blk, $urandom_range(0, 3), (op != 2'd3) && ($urandom_range(0, 7) == 0));
        end

        // Reset while waiting for a result.
        t_ack = 0; t_hold_start = 1; t_never = 1'b1;
        rand_words();
        push_cmds(2'd0, blk);
        issue(2'd0, blk);
        n = 0;
        while (exp_cmd_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reset_reached_wait", 256'(exp_cmd_q.size()), 256'(0));
        exp_cmd_q.delete();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cmd_status", 256'(cmd_status), 256'(0));
        chk("mid_rst_cmd_arg0", 256'(cmd_arg[0]), 256'(0));
        chk("mid_rst_resp_valid", 256'(resp_valid), 256'(0));
        chk("mid_rst_resp_error", 256'(resp_error), 256'(0));
        chk("mid_rst_resp_data", 256'(resp_data), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        t_never = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 256'(req_ready), 256'(1));
        repeat (20) @(negedge clk);
        chk("post_rst_no_resp", 256'(resp_valid), 256'(0));
        chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
